// File: rtl/dm_unit_pkg.sv
// -----------------------------------------------------------------------------
// dm_unit_pkg
// Shared definitions for the data-memory stage: the dmType access encoding,
// which the core's controller also uses, and a helper that says whether a
// dmType value names a real access.
// -----------------------------------------------------------------------------
package dm_unit_pkg;

  localparam int DMTYPE_W = 3;

  // Access type encoding. 101..111 are illegal.
  typedef enum logic [DMTYPE_W-1:0] {
    DM_WORD   = 3'b000,
    DM_HALF   = 3'b001,
    DM_HALF_U = 3'b010,
    DM_BYTE   = 3'b011,
    DM_BYTE_U = 3'b100
  } dm_type_e;

  function automatic logic dm_type_legal(input logic [DMTYPE_W-1:0] t);
    logic legal;
    case (t)
      DM_WORD, DM_HALF, DM_HALF_U, DM_BYTE, DM_BYTE_U: legal = 1'b1;
      default:                                         legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/dm_unit_if.sv
// -----------------------------------------------------------------------------
// dm_unit_if
// Bus between the single-cycle core (master) and the data-memory stage
// (slave).
//   mem_w        core -> dm : store request this cycle
//   dmType       core -> dm : access type (dm_unit_pkg::dm_type_e encoding)
//   addr         core -> dm : byte address from the ALU
//   din          core -> dm : store data (rs2)
//   err_clr      core -> dm : synchronous clear of the sticky error flags
//   dout         dm -> core : combinational, extended load data
//   misalign_err dm -> core : sticky, misaligned store dropped
//   range_err    dm -> core : sticky, out-of-range store dropped
//   err_addr     dm -> core : address of first dropped store since clear
//   st_cnt       dm -> core : committed store count
// -----------------------------------------------------------------------------
interface dm_unit_if;
  import dm_unit_pkg::*;

  logic                mem_w;
  logic [DMTYPE_W-1:0] dmType;
  logic [31:0]         addr;
  logic [31:0]         din;
  logic                err_clr;
  logic [31:0]         dout;
  logic                misalign_err;
  logic                range_err;
  logic [31:0]         err_addr;
  logic [31:0]         st_cnt;

  modport master (
    output mem_w, dmType, addr, din, err_clr,
    input  dout, misalign_err, range_err, err_addr, st_cnt
  );

  modport slave (
    input  mem_w, dmType, addr, din, err_clr,
    output dout, misalign_err, range_err, err_addr, st_cnt
  );
endinterface

// File: rtl/dm_unit_ldext.sv
// -----------------------------------------------------------------------------
// dm_unit_ldext
// Combinational lane selector and sign/zero extender for loads. The
// misaligned flag depends only on offset and type, so the store path uses
// the same instance to decide whether a store is aligned.
//   word_i       : 32-bit word read from the array
//   off_i        : byte offset addr[1:0]
//   dm_type_i    : access type
//   data_o       : extended load data, 0 when misaligned or illegal type
//   misaligned_o : access is misaligned for its type (0 for illegal types)
// -----------------------------------------------------------------------------
module dm_unit_ldext
  import dm_unit_pkg::*;
(
  input  logic [31:0]         word_i,
  input  logic [1:0]          off_i,
  input  logic [DMTYPE_W-1:0] dm_type_i,
  output logic [31:0]         data_o,
  output logic                misaligned_o
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic        mis;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (off_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase

    data_o = '0;
    mis    = 1'b0;
    case (dm_type_i)
      DM_WORD: begin
        mis = (off_i != 2'b00);
        if (!mis) data_o = word_i;
      end
      DM_HALF: begin
        mis = off_i[0];
        if (!mis) data_o = {{16{half_sel[15]}}, half_sel};
      end
      DM_HALF_U: begin
        mis = off_i[0];
        if (!mis) data_o = {16'h0000, half_sel};
      end
      DM_BYTE:   data_o = {{24{byte_sel[7]}}, byte_sel};
      DM_BYTE_U: data_o = {24'h000000, byte_sel};
      default:   ;
    endcase
    misaligned_o = mis;
  end

endmodule

// File: rtl/dm_unit.sv
// -----------------------------------------------------------------------------
// dm_unit
// Data-memory stage behind the single-cycle core. Byte-lane stores commit on
// the clock edge; loads are combinational and see the array contents before
// any store on the same edge. Faulting stores are dropped and recorded in
// sticky flags with the address of the first fault.
//   clk   : clock, all state on posedge
//   reset : asynchronous, active-low
//   bus   : dm_unit_if.slave (see interface for signal list)
// -----------------------------------------------------------------------------
module dm_unit
  import dm_unit_pkg::*;
#(
  parameter int          DEPTH_LOG2   = 10,
  parameter logic [31:0] ERR_ADDR_RST = 32'h0
) (
  input  logic      clk,
  input  logic      reset,
  dm_unit_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  in_range;
  logic                  legal;
  logic                  misaligned;
  logic [31:0]           ld_data;

  logic                  commit;
  logic                  fault_mis;
  logic                  fault_rng;
  logic                  capture;
  logic [3:0]            lane_en;
  logic [31:0]           wdata;

  logic                  misalign_err_q, misalign_err_d;
  logic                  range_err_q,    range_err_d;
  logic [31:0]           err_addr_q,     err_addr_d;
  logic [31:0]           st_cnt_q,       st_cnt_d;

  assign idx      = bus.addr[DEPTH_LOG2+1:2];
  assign in_range = (bus.addr[31:DEPTH_LOG2+2] == '0);
  assign legal    = dm_type_legal(bus.dmType);

  dm_unit_ldext u_ldext (
    .word_i       (mem_q[idx]),
    .off_i        (bus.addr[1:0]),
    .dm_type_i    (bus.dmType),
    .data_o       (ld_data),
    .misaligned_o (misaligned)
  );

  assign bus.dout = in_range ? ld_data : '0;

  // Out of range wins over misaligned, so at most one fault fires per store.
  assign fault_rng = bus.mem_w && legal && !in_range;
  assign fault_mis = bus.mem_w && legal && in_range && misaligned;
  assign commit    = bus.mem_w && legal && in_range && !misaligned;

  // The clear applies before the new fault, so a fault on a clearing edge
  // counts as the first one and recaptures the address.
  assign capture = (fault_rng || fault_mis) &&
                   (bus.err_clr || !(misalign_err_q || range_err_q));

  // Lane enables and lane-replicated write data.
  always_comb begin
    lane_en = 4'b0000;
    wdata   = bus.din;
    case (bus.dmType)
      DM_WORD: lane_en = 4'b1111;
      DM_HALF, DM_HALF_U: begin
        lane_en = bus.addr[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{bus.din[15:0]}};
      end
      DM_BYTE, DM_BYTE_U: begin
        lane_en = 4'b0001 << bus.addr[1:0];
        wdata   = {4{bus.din[7:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    misalign_err_d = (bus.err_clr ? 1'b0 : misalign_err_q) | fault_mis;
    range_err_d    = (bus.err_clr ? 1'b0 : range_err_q) | fault_rng;
    err_addr_d     = capture ? bus.addr : err_addr_q;
    st_cnt_d       = commit ? st_cnt_q + 32'd1 : st_cnt_q;
  end

  // NOTE: the array has no reset so it maps onto RAM; the write is gated by
  // reset instead, which keeps a store from landing while reset is held.
  always_ff @(posedge clk) begin
    if (commit && reset) begin
      for (int l = 0; l < 4; l++) begin
        if (lane_en[l]) mem_q[idx][8*l +: 8] <= wdata[8*l +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_err_q <= 1'b0;
      range_err_q    <= 1'b0;
      err_addr_q     <= ERR_ADDR_RST;
      st_cnt_q       <= '0;
    end else begin
      misalign_err_q <= misalign_err_d;
      range_err_q    <= range_err_d;
      err_addr_q     <= err_addr_d;
      st_cnt_q       <= st_cnt_d;
    end
  end

  assign bus.misalign_err = misalign_err_q;
  assign bus.range_err    = range_err_q;
  assign bus.err_addr     = err_addr_q;
  assign bus.st_cnt       = st_cnt_q;

endmodule

// File: tb/tb_dm_unit.sv
// -----------------------------------------------------------------------------
// tb_dm_unit
// Directed, table-driven bench for dm_unit with DEPTH_LOG2=10. Each record
// drives one cycle, checks the combinational load data before the edge and
// the registered error/count state after it. Hand-written sequences cover
// the asynchronous reset during a store and read-during-write.
// -----------------------------------------------------------------------------
module tb_dm_unit;
  import dm_unit_pkg::*;

  localparam logic [2:0] W = 3'd0, H = 3'd1, HU = 3'd2, B = 3'd3, BU = 3'd4;

  typedef struct {
    logic        mem_w;
    logic [2:0]  dm;
    logic [31:0] addr;
    logic [31:0] din;
    logic        clr;
    logic        chk_dout;
    logic [31:0] dout;
    logic        mis;
    logic        rng;
    logic [31:0] ea;
    logic [31:0] st;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  dm_unit_if bus_if ();

  dm_unit #(.DEPTH_LOG2(10), .ERR_ADDR_RST(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic mw, input logic [2:0] dm,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic clr, input logic cd,
                             input logic [31:0] dout, input logic mis,
                             input logic rng, input logic [31:0] ea,
                             input logic [31:0] st);
    vec_t r;
    r.mem_w = mw; r.dm = dm; r.addr = a; r.din = d; r.clr = clr;
    r.chk_dout = cd; r.dout = dout; r.mis = mis; r.rng = rng;
    r.ea = ea; r.st = st;
    return r;
  endfunction

  task automatic drive(input logic mw, input logic [2:0] dm,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic clr);
    bus_if.mem_w   = mw;
    bus_if.dmType  = dm;
    bus_if.addr    = a;
    bus_if.din     = d;
    bus_if.err_clr = clr;
  endtask

  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    drive(t.mem_w, t.dm, t.addr, t.din, t.clr);
    #1;
    if (t.chk_dout) check({tag, ".dout"}, bus_if.dout, t.dout);
    @(posedge clk);
    #1;
    check({tag, ".misalign_err"}, {31'd0, bus_if.misalign_err}, {31'd0, t.mis});
    check({tag, ".range_err"}, {31'd0, bus_if.range_err}, {31'd0, t.rng});
    check({tag, ".err_addr"}, bus_if.err_addr, t.ea);
    check({tag, ".st_cnt"}, bus_if.st_cnt, t.st);
  endtask

  initial begin
    //              mw  dm  addr          din           clr cd dout          mis rng ea            st
    vecs.push_back(v(1, W,  32'h10,       32'hDEADBEEF, 0, 0, 32'h0,        0, 0, 32'h0,      32'd1));
    vecs.push_back(v(0, W,  32'h10,       32'h0,        0, 1, 32'hDEADBEEF, 0, 0, 32'h0,      32'd1));
    vecs.push_back(v(0, B,  32'h13,       32'h0,        0, 1, 32'hFFFFFFDE, 0, 0, 32'h0,      32'd1));
    vecs.push_back(v(0, BU, 32'h13,       32'h0,        0, 1, 32'h000000DE, 0, 0, 32'h0,      32'd1));
    vecs.push_back(v(0, H,  32'h10,       32'h0,        0, 1, 32'hFFFFBEEF, 0, 0, 32'h0,      32'd1));
    vecs.push_back(v(1, B,  32'h11,       32'h12345678, 0, 1, 32'hFFFFFFBE, 0, 0, 32'h0,      32'd2));
    vecs.push_back(v(0, W,  32'h10,       32'h0,        0, 1, 32'hDEAD78EF, 0, 0, 32'h0,      32'd2));
    vecs.push_back(v(1, H,  32'h12,       32'h0000A5A5, 0, 1, 32'hFFFFDEAD, 0, 0, 32'h0,      32'd3));
    vecs.push_back(v(0, W,  32'h10,       32'h0,        0, 1, 32'hA5A578EF, 0, 0, 32'h0,      32'd3));
    vecs.push_back(v(0, HU, 32'h12,       32'h0,        0, 1, 32'h0000A5A5, 0, 0, 32'h0,      32'd3));
    vecs.push_back(v(0, HU, 32'h10,       32'h0,        0, 1, 32'h000078EF, 0, 0, 32'h0,      32'd3));
    vecs.push_back(v(1, W,  32'h20,       32'h0BADF00D, 0, 0, 32'h0,        0, 0, 32'h0,      32'd4));
    vecs.push_back(v(1, W,  32'h22,       32'hFFFFFFFF, 0, 1, 32'h0,        1, 0, 32'h22,     32'd4));
    vecs.push_back(v(1, H,  32'h25,       32'hFFFFFFFF, 0, 1, 32'h0,        1, 0, 32'h22,     32'd4));
    vecs.push_back(v(0, W,  32'h22,       32'h0,        0, 1, 32'h0,        1, 0, 32'h22,     32'd4));
    vecs.push_back(v(0, W,  32'h20,       32'h0,        0, 1, 32'h0BADF00D, 1, 0, 32'h22,     32'd4));
    vecs.push_back(v(0, W,  32'h10,       32'h0,        1, 1, 32'hA5A578EF, 0, 0, 32'h22,     32'd4));
    vecs.push_back(v(1, W,  32'h1000,     32'h1,        0, 1, 32'h0,        0, 1, 32'h1000,   32'd4));
    vecs.push_back(v(1, H,  32'h1001,     32'h1,        0, 1, 32'h0,        0, 1, 32'h1000,   32'd4));
    vecs.push_back(v(0, W,  32'h1000,     32'h0,        0, 1, 32'h0,        0, 1, 32'h1000,   32'd4));
    vecs.push_back(v(1, H,  32'h0F,       32'h1,        0, 1, 32'h0,        1, 1, 32'h1000,   32'd4));
    vecs.push_back(v(1, H,  32'h31,       32'h0,        1, 1, 32'h0,        1, 0, 32'h31,     32'd4));
    vecs.push_back(v(0, W,  32'h10,       32'h0,        1, 1, 32'hA5A578EF, 0, 0, 32'h31,     32'd4));
    vecs.push_back(v(1, 3'd5, 32'h10,     32'h0,        0, 1, 32'h0,        0, 0, 32'h31,     32'd4));
    vecs.push_back(v(0, W,  32'h10,       32'h0,        0, 1, 32'hA5A578EF, 0, 0, 32'h31,     32'd4));
    vecs.push_back(v(1, B,  32'hFFF,      32'h000000AB, 0, 0, 32'h0,        0, 0, 32'h31,     32'd5));
    vecs.push_back(v(0, BU, 32'hFFF,      32'h0,        0, 1, 32'h000000AB, 0, 0, 32'h31,     32'd5));
    vecs.push_back(v(0, B,  32'hFFF,      32'h0,        0, 1, 32'hFFFFFFAB, 0, 0, 32'h31,     32'd5));
    vecs.push_back(v(0, BU, 32'h13,       32'h0,        0, 1, 32'h000000A5, 0, 0, 32'h31,     32'd5));
    vecs.push_back(v(0, B,  32'h11,       32'h0,        0, 1, 32'h00000078, 0, 0, 32'h31,     32'd5));
    // Set-up for the reset sequence: a flag set and a known value at 0x40.
    vecs.push_back(v(1, W,  32'h42,       32'h0,        0, 1, 32'h0,        1, 0, 32'h42,     32'd5));
    vecs.push_back(v(1, W,  32'h40,       32'h55AA55AA, 0, 0, 32'h0,        1, 0, 32'h42,     32'd6));

    // Reset state.
    reset = 1'b0;
    drive(1'b0, W, 32'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst.misalign_err", {31'd0, bus_if.misalign_err}, 32'd0);
    check("rst.range_err", {31'd0, bus_if.range_err}, 32'd0);
    check("rst.err_addr", bus_if.err_addr, 32'h0);
    check("rst.st_cnt", bus_if.st_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("v%0d", i));
    end

    // Asynchronous reset between edges while a store to 0x40 is pending.
    @(negedge clk);
    drive(1'b1, W, 32'h40, 32'h12345678, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("arst.misalign_err", {31'd0, bus_if.misalign_err}, 32'd0);
    check("arst.range_err", {31'd0, bus_if.range_err}, 32'd0);
    check("arst.err_addr", bus_if.err_addr, 32'h0);
    check("arst.st_cnt", bus_if.st_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, W, 32'h40, 32'h0, 1'b0);
    #1;
    check("arst.mem40", bus_if.dout, 32'h55AA55AA);
    @(posedge clk);
    #1;
    check("arst.st_cnt_after", bus_if.st_cnt, 32'd0);

    // Read during write at 0x44.
    apply(v(1, W, 32'h44, 32'h22222222, 0, 0, 32'h0, 0, 0, 32'h0, 32'd1), "rdw.pre");
    @(negedge clk);
    drive(1'b1, W, 32'h44, 32'h11111111, 1'b0);
    #1;
    check("rdw.old", bus_if.dout, 32'h22222222);
    @(posedge clk);
    #1;
    check("rdw.st_cnt", bus_if.st_cnt, 32'd2);
    @(negedge clk);
    drive(1'b0, W, 32'h44, 32'h0, 1'b0);
    #1;
    check("rdw.new", bus_if.dout, 32'h11111111);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dm_unit.md
Name: dm_unit

Overview:
- Data-memory stage directly downstream of the single-cycle core.
- Consumes the core's mem_w, ALU address, store data and dmType; returns load data on the same cycle for register write-back.
- Provides byte/halfword/word stores through lane enables, and sign/zero-extended loads.
- Suppresses faulting stores (misaligned or out of range) and logs them in sticky error registers, so software and the bench can detect them.

Parameters:
- DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (default 1024 words = 4 KiB).
- ERR_ADDR_RST, 32'h0, reset value of err_addr.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- mem_w  in  1  store request for the current cycle.
- dmType  in  3  access type for both load and store.
- addr  in  32  byte address from the ALU.
- din  in  32  store data, taken from the rs2 read port.
- dout  out  32  load data, combinational, extended per dmType.
- err_clr  in  1  synchronous clear of both sticky error flags.
- misalign_err  out  1  sticky: a misaligned store was dropped.
- range_err  out  1  sticky: an out-of-range store was dropped.
- err_addr  out  32  address of the first dropped store since the last clear or reset.
- st_cnt  out  32  count of committed stores.

Behaviour:
- dmType encoding, shared with the controller:
  - 000 word
  - 001 half signed
  - 010 half unsigned
  - 011 byte signed
  - 100 byte unsigned
  - 101-111 illegal
- Word index is addr[DEPTH_LOG2+1:2].
- In range means addr[31:DEPTH_LOG2+2] == 0.
- Aligned means:
  - word: addr[1:0] == 0
  - half: addr[0] == 0
  - byte: always aligned
- Store commit, at posedge when reset=1, mem_w=1, legal dmType, in range and aligned:
  - byte: din[7:0] is written to lane addr[1:0].
  - half: din[15:0] is written to lanes {addr[1],0} and {addr[1],1}.
  - word: all 4 lanes are written.
  - Other lanes of the word are untouched.
  - st_cnt increments by 1 and wraps from FFFF_FFFF to 0.
- Dropped store (mem_w=1 and out of range or misaligned):
  - Memory and st_cnt are unchanged.
  - range_err is set if out of range. misalign_err is set if in range but misaligned. Out of range takes priority; only one flag is set per store.
  - err_addr captures addr only when both flags were 0 before that edge.
- Illegal dmType with mem_w=1: no write, no flag, st_cnt unchanged.
- Load path (combinational, independent of mem_w):
  - Selects the word at the index, then the lane per addr[1:0] and dmType.
  - Signed types replicate the MSB of the selected field; unsigned types zero-fill.
  - dout = 0 when out of range, misaligned, or dmType is illegal.
- Read during write: a same-cycle load of the address being stored returns the old contents; the new value is visible from the next cycle.
- err_clr=1 at posedge clears both flags. err_addr holds its value.
- If a dropped store occurs on the same edge as err_clr, the new error wins: its flag is set, and err_addr is recaptured because the clear takes effect first.
- Reset (reset=0), asynchronous, also mid-store:
  - misalign_err=0, range_err=0, err_addr=ERR_ADDR_RST, st_cnt=0.
  - Any in-flight store is not committed.
  - Memory array contents are not reset.
- dout has no reset value; it follows the array contents.
- Latency: load 0 cycles (combinational); store 1 edge.

Decomposition:
- Shared in ctrl_encode_def.v:
  - dm_word / dm_halfword / dm_halfword_unsigned / dm_byte / dm_byte_unsigned defines (values as above).
  - DMTYPE_W = 3.
- Sub-module dm_ldext (combinational): inputs word, addr[1:0], dmType; outputs extended data and a misaligned bit. It is reused by the aligned check on the store path.
- The top holds the array, byte-lane write enables, flags, err_addr and st_cnt.

Test Plan:
- Word store/load:
  - reset low→high; sw din=DEADBEEF at addr 0x10 → st_cnt=1.
  - lw at 0x10 → dout=DEADBEEF.
  - lb at 0x13 → FFFFFFDE.
  - lbu at 0x13 → 000000DE.
  - lh at 0x10 → FFFFBEEF.
- Lane isolation:
  - sb din=0x12345678 to 0x11 over word 0 → lw at 0x10 → DEAD78EF.
  - sh din=0x0000A5A5 to 0x12 → DEAD78EF becomes A5A578EF; lhu at 0x12 → 0000A5A5.
- Misaligned store:
  - sw to 0x22 → memory unchanged, misalign_err=1, err_addr=0x22, st_cnt unchanged.
  - Then sh to 0x25 → err_addr stays 0x22.
  - Load lw at 0x22 → dout=0.
- Range error and priority:
  - sw to 0x0000_1000 (DEPTH_LOG2=10) → range_err=1, misalign_err=0.
  - sh to 0x0000_1001 → range_err only.
  - lw at 0x1000 → dout=0.
- Clear collision:
  - With flags set, err_clr=1 on the same edge as a misaligned sh to 0x31 → misalign_err=1, range_err=0, err_addr=0x31.
  - err_clr alone → both flags 0, err_addr=0x31.
- Async reset:
  - Drop reset between edges while mem_w=1 sw to 0x40 → flags and st_cnt go 0 immediately; 0x40 is not written.
  - Read-during-write: sw 0x11111111 to 0x44 while reading 0x44 → old value that cycle, 11111111 the next.
